// File: rtl/demux8_seq.sv
// Eight-slot frame assembler: words are steered into registered slots either by
// an internal fill pointer or by an explicit address, and released per frame.
module demux8_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             auto,
    input  logic [2:0]       select,
    input  logic             clear,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] d4,
    output logic [WIDTH-1:0] d5,
    output logic [WIDTH-1:0] d6,
    output logic [WIDTH-1:0] d7,
    output logic [7:0]       valid_mask,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic [15:0]      frame_count
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       mask_q, mask_d;
    logic [15:0]      count_q, count_d;
    logic [WIDTH-1:0] slot_q [8];
    logic [WIDTH-1:0] slot_d [8];

    logic       accept;
    logic [2:0] target;
    logic [7:0] mask_set;

    assign in_ready = (state_q == FILL);
    assign accept   = in_valid && in_ready;
    assign target   = auto ? ptr_q : select;
    assign mask_set = mask_q | (8'b1 << target);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        count_d = count_q;
        slot_d  = slot_q;

        if (clear) begin
            // Clear wins over both a pending accept and a frame release.
            state_d = FILL;
            ptr_d   = 3'd0;
            mask_d  = 8'd0;
            for (int i = 0; i < 8; i++) slot_d[i] = '0;
        end else if (state_q == FULL) begin
            if (frame_ack) begin
                state_d = FILL;
                ptr_d   = 3'd0;
                mask_d  = 8'd0;
                count_d = count_q + 16'd1;
            end
        end else if (accept) begin
            slot_d[target] = data_in;
            mask_d         = mask_set;
            if (auto) ptr_d = ptr_q + 3'd1;
            if (mask_set == 8'hFF) state_d = FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            ptr_q   <= 3'd0;
            mask_q  <= 8'd0;
            count_q <= 16'd0;
            // NOTE: slot storage is reset too, since a reset must discard frame contents.
            for (int i = 0; i < 8; i++) slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            slot_q  <= slot_d;
        end
    end

    assign d0          = slot_q[0];
    assign d1          = slot_q[1];
    assign d2          = slot_q[2];
    assign d3          = slot_q[3];
    assign d4          = slot_q[4];
    assign d5          = slot_q[5];
    assign d6          = slot_q[6];
    assign d7          = slot_q[7];
    assign valid_mask  = mask_q;
    assign frame_valid = (state_q == FULL);
    assign frame_count = count_q;

endmodule

// File: tb/tb_demux8_seq.sv
// Directed bench for demux8_seq: a vector table for fill/hold/ack plus
// hand-written sequences for overwrite, mixed modes, clear and async reset.
module tb_demux8_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic        auto;
    logic [2:0]  select;
    logic        clear;
    logic [31:0] d_out [8];
    logic [7:0]  valid_mask;
    logic        frame_valid;
    logic        frame_ack;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_pass   = 0;

    demux8_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .auto        (auto),
        .select      (select),
        .clear       (clear),
        .d0          (d_out[0]),
        .d1          (d_out[1]),
        .d2          (d_out[2]),
        .d3          (d_out[3]),
        .d4          (d_out[4]),
        .d5          (d_out[5]),
        .d6          (d_out[6]),
        .d7          (d_out[7]),
        .valid_mask  (valid_mask),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        auto_m;
        logic [2:0]  sel;
        logic [31:0] data;
        logic        ack;
        logic        clr;
        logic [7:0]  exp_mask;
        logic        exp_fv;
        logic        exp_ready;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic a, input logic [2:0] s,
                         input logic [31:0] d, input logic ak, input logic c);
        in_valid  = v;
        auto      = a;
        select    = s;
        data_in   = d;
        frame_ack = ak;
        clear     = c;
    endtask

    // Sample one time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 3'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset state
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset frame_valid", frame_valid, 0);
        check("reset valid_mask", valid_mask, 0);
        check("reset frame_count", frame_count, 0);
        check("reset d0", d_out[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Sequential fill, hold with ignored words, ack, ack ignored in FILL
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 1'b1, 3'd0, 32'h10 + 32'(i), 1'b0, 1'b0,
                        8'((16'd1 << (i + 1)) - 16'd1), (i == 7), (i != 7), 16'd0};
        for (int i = 8; i < 13; i++)
            vecs[i] = '{1'b1, 1'b1, 3'd0, 32'hEE, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 16'd0};
        vecs[13] = '{1'b1, 1'b1, 3'd0, 32'hEE, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd1};
        vecs[14] = '{1'b0, 1'b1, 3'd0, 32'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd1};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].valid, vecs[i].auto_m, vecs[i].sel, vecs[i].data, vecs[i].ack, vecs[i].clr);
            step();
            check($sformatf("vec%0d valid_mask", i), valid_mask, vecs[i].exp_mask);
            check($sformatf("vec%0d frame_valid", i), frame_valid, vecs[i].exp_fv);
            check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d frame_count", i), frame_count, vecs[i].exp_count);
        end
        idle();
        for (int i = 0; i < 8; i++)
            check($sformatf("retained d%0d", i), d_out[i], 32'h10 + 32'(i));

        // Addressed overwrite
        drive(1'b1, 1'b0, 3'd3, 32'hA, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 3'd3, 32'hB, 1'b0, 1'b0); step();
        idle();
        check("overwrite d3", d_out[3], 32'hB);
        check("overwrite valid_mask", valid_mask, 8'h08);
        check("overwrite frame_valid", frame_valid, 0);

        // Plain clear
        drive(1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b1); step();
        idle();
        check("clear d3", d_out[3], 0);
        check("clear d7", d_out[7], 0);
        check("clear valid_mask", valid_mask, 0);
        check("clear frame_count", frame_count, 1);

        // Mixed modes: 3 auto words then slots 7..3 addressed
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 3'd0, 32'h20 + 32'(i), 1'b0, 1'b0); step();
        end
        for (int s = 7; s >= 3; s--) begin
            drive(1'b1, 1'b0, 3'(s), 32'h30 + 32'(s), 1'b0, 1'b0); step();
        end
        check("mixed frame_valid", frame_valid, 1);
        check("mixed d0", d_out[0], 32'h20);
        check("mixed d2", d_out[2], 32'h22);
        check("mixed d3", d_out[3], 32'h33);
        check("mixed d7", d_out[7], 32'h37);
        drive(1'b1, 1'b1, 3'd0, 32'h99, 1'b0, 1'b0); step();
        check("blocked d0", d_out[0], 32'h20);
        check("blocked valid_mask", valid_mask, 8'hFF);
        drive(1'b1, 1'b1, 3'd0, 32'h99, 1'b1, 1'b0); step();
        check("ack-cycle word dropped", valid_mask, 8'h00);
        check("ack count", frame_count, 2);
        check("ack retains d3", d_out[3], 32'h33);
        drive(1'b1, 1'b1, 3'd0, 32'h99, 1'b0, 1'b0); step();
        check("post-ack d0 (ptr reset)", d_out[0], 32'h99);
        check("post-ack valid_mask", valid_mask, 8'h01);

        // Pointer resumes after an addressed write
        drive(1'b1, 1'b0, 3'd5, 32'h55, 1'b0, 1'b0); step();
        drive(1'b1, 1'b1, 3'd5, 32'h66, 1'b0, 1'b0); step();
        drive(1'b1, 1'b1, 3'd0, 32'h77, 1'b0, 1'b0); step();
        check("resume d1", d_out[1], 32'h66);
        check("resume d2", d_out[2], 32'h77);
        check("resume valid_mask", valid_mask, 8'h27);

        // Clear beats a simultaneous accept after 4 accepts
        drive(1'b1, 1'b1, 3'd0, 32'hFF, 1'b0, 1'b1); step();
        idle();
        check("clr-prio d0", d_out[0], 0);
        check("clr-prio d2", d_out[2], 0);
        check("clr-prio d5", d_out[5], 0);
        check("clr-prio valid_mask", valid_mask, 0);
        check("clr-prio frame_count", frame_count, 2);
        drive(1'b1, 1'b1, 3'd0, 32'h44, 1'b0, 1'b0); step();
        check("clr-prio ptr0 d0", d_out[0], 32'h44);
        check("clr-prio ptr0 mask", valid_mask, 8'h01);

        // Clear beats frame_ack in FULL
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 1'b1, 3'd0, 32'h80 + 32'(i), 1'b0, 1'b0); step();
        end
        check("refill frame_valid", frame_valid, 1);
        drive(1'b0, 1'b1, 3'd0, 32'h0, 1'b1, 1'b1); step();
        idle();
        check("clr+ack frame_count", frame_count, 2);
        check("clr+ack frame_valid", frame_valid, 0);
        check("clr+ack d7", d_out[7], 0);

        // Async reset while FULL, between edges
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 3'd0, 32'hC0 + 32'(i), 1'b0, 1'b0); step();
        end
        idle();
        check("pre-reset frame_valid", frame_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async in_ready", in_ready, 1);
        check("async frame_valid", frame_valid, 0);
        check("async valid_mask", valid_mask, 0);
        check("async frame_count", frame_count, 0);
        check("async d4", d_out[4], 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
